// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace buffer.
// WB_TRACE_TIMESTAMP_EN adds a per-entry stamp field.
package wb_trace_pkg;

    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int STAMP_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]   wreg;
        logic [DATA_W-1:0]  data;
`ifdef WB_TRACE_TIMESTAMP_EN
        logic [STAMP_W-1:0] stamp;
`endif
    } wb_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; no fall-through, pops of an empty
// FIFO are ignored, and a push into a full FIFO is accepted only alongside a pop.
module wb_trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/wb_trace_buffer.sv
// Logs one entry per committed register write, detected on rising edges of proc_clk_in
// sampled as data. WB_TRACE_TIMESTAMP_EN adds a stamp counter and the rd_stamp port.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int LOG_R0 = 0,
    parameter int DROP_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   proc_clk_in,
    input  logic                   wb_en,
    input  logic [4:0]             wb_reg,
    input  logic [31:0]            wb_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [4:0]             rd_reg,
    output logic [31:0]            rd_data,
`ifdef WB_TRACE_TIMESTAMP_EN
    output logic [31:0]            rd_stamp,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int ENTRY_W = $bits(wb_entry_t);

    logic      pclk_q;
    logic      pclk_rise;
    logic      cap;
    logic      pop;
    logic      drop;
    logic      full;
    logic      empty;
    wb_entry_t wr_entry;
    wb_entry_t rd_entry;

    // Resetting pclk_q high suppresses a false edge when proc_clk_in is already high.
    always_ff @(posedge clock) begin
        if (reset) pclk_q <= 1'b1;
        else       pclk_q <= proc_clk_in;
    end

    assign pclk_rise = proc_clk_in & ~pclk_q;
    assign cap       = pclk_rise & wb_en & ((LOG_R0 != 0) | (wb_reg != 5'd0));
    assign pop       = rd_valid & rd_ready;
    assign drop      = cap & full & ~pop;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp;

    // Counts every processor clock edge, captured or not.
    always_ff @(posedge clock) begin
        if (reset)          stamp <= '0;
        else if (pclk_rise) stamp <= stamp + 1'b1;
    end
`endif

    always_comb begin
        wr_entry       = '0;
        wr_entry.wreg  = wb_reg;
        wr_entry.data  = wb_data;
`ifdef WB_TRACE_TIMESTAMP_EN
        wr_entry.stamp = stamp;
`endif
    end

    wb_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (cap),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Head fields are masked so they read as zero while nothing is queued.
    assign rd_valid = ~empty;
    assign rd_reg   = rd_valid ? rd_entry.wreg : 5'd0;
    assign rd_data  = rd_valid ? rd_entry.data : 32'd0;
`ifdef WB_TRACE_TIMESTAMP_EN
    assign rd_stamp = rd_valid ? rd_entry.stamp : 32'd0;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: a per-cycle vector table plus hand-written
// overflow, full-with-pop and reset sequences. Honours WB_TRACE_TIMESTAMP_EN.
module tb_wb_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        proc_clk_in;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        rd_ready;

    logic        v0, v1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic [4:0]  c0, c1;
    logic        of0, of1;
    logic [15:0] dc0, dc1;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [31:0] s0, s1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    wb_trace_buffer #(.DEPTH(16), .LOG_R0(0), .DROP_W(16)) dut0 (
        .clock(clock), .reset(reset), .proc_clk_in(proc_clk_in), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .rd_valid(v0), .rd_ready(rd_ready),
        .rd_reg(r0), .rd_data(d0),
`ifdef WB_TRACE_TIMESTAMP_EN
        .rd_stamp(s0),
`endif
        .count(c0), .overflow(of0), .drop_cnt(dc0)
    );

    wb_trace_buffer #(.DEPTH(16), .LOG_R0(1), .DROP_W(16)) dut1 (
        .clock(clock), .reset(reset), .proc_clk_in(proc_clk_in), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .rd_valid(v1), .rd_ready(rd_ready),
        .rd_reg(r1), .rd_data(d1),
`ifdef WB_TRACE_TIMESTAMP_EN
        .rd_stamp(s1),
`endif
        .count(c1), .overflow(of1), .drop_cnt(dc1)
    );

    typedef struct {
        logic        pclk;
        logic        en;
        logic        rdy;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        ev;
        logic [4:0]  er;
        logic [31:0] ed;
        logic [4:0]  ec;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic write_pulse(input logic [4:0] rg, input logic [31:0] dt);
        proc_clk_in = 1'b1; wb_en = 1'b1; wb_reg = rg; wb_data = dt;
        cyc();
        proc_clk_in = 1'b0; wb_en = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; proc_clk_in = 1'b0; wb_en = 1'b0;
        wb_reg = 5'd0; wb_data = 32'd0; rd_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", {31'd0, v0}, 32'd0);
        chk("rst_count", {27'd0, c0}, 32'd0);
        chk("rst_overflow", {31'd0, of0}, 32'd0);
        chk("rst_drop_cnt", {16'd0, dc0}, 32'd0);
        chk("rst_rd_reg", {27'd0, r0}, 32'd0);
        chk("rst_rd_data", d0, 32'd0);
        reset = 1'b0;
        cyc();

        // Test 1: three writes with rd_ready high; Test 2: wb_en held across a period.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd1, 32'h1111_1111, 5'd1};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'd1, 32'h1111_1111, 1'b0, 5'd0, 32'h0, 5'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 5'd2, 32'h2222_2222, 5'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 5'd0, 32'h0, 5'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd3, 32'h3333_3333, 5'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 32'h0, 5'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd5, 32'h5555_5555, 1'b0, 5'd0, 32'h0, 5'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 5'd5, 32'h5555_5555, 1'b1, 5'd5, 32'h5555_5555, 5'd1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 5'd5, 32'h5555_5555, 1'b1, 5'd5, 32'h5555_5555, 5'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 5'd5, 32'h5555_5555, 1'b1, 5'd5, 32'h5555_5555, 5'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0, 5'd0};

        for (int i = 0; i < 16; i++) begin
            proc_clk_in = tbl[i].pclk; wb_en = tbl[i].en; rd_ready = tbl[i].rdy;
            wb_reg = tbl[i].wreg; wb_data = tbl[i].wdata;
            cyc();
            chk($sformatf("tbl%0d_valid", i), {31'd0, v0}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_count", i), {27'd0, c0}, {27'd0, tbl[i].ec});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_reg", i), {27'd0, r0}, {27'd0, tbl[i].er});
                chk($sformatf("tbl%0d_data", i), d0, tbl[i].ed);
            end
        end

        // Test 3: r0 write is filtered unless LOG_R0 is set.
        rd_ready = 1'b0;
        cyc();
        write_pulse(5'd0, 32'hDEAD_0000);
        chk("r0_nolog_count", {27'd0, c0}, 32'd0);
        chk("r0_nolog_valid", {31'd0, v0}, 32'd0);
        chk("r0_log_count", {27'd0, c1}, 32'd1);
        chk("r0_log_reg", {27'd0, r1}, 32'd0);
        chk("r0_log_data", d1, 32'hDEAD_0000);
        rd_ready = 1'b1;
        cyc();
        chk("r0_log_drained", {27'd0, c1}, 32'd0);
        rd_ready = 1'b0;

        // Test 4: 18 writes into a 16-deep FIFO with no reader.
        for (int i = 1; i <= 18; i++) begin
            write_pulse(5'(i), 32'hA000_0000 + 32'(i));
            if (i == 16) begin
                chk("full_count16", {27'd0, c0}, 32'd16);
                chk("full_no_overflow", {31'd0, of0}, 32'd0);
            end
        end
        chk("ovf_count", {27'd0, c0}, 32'd16);
        chk("ovf_flag", {31'd0, of0}, 32'd1);
        chk("ovf_drop_cnt", {16'd0, dc0}, 32'd2);
        chk("ovf_head_reg", {27'd0, r0}, 32'd1);
        chk("ovf_head_data", d0, 32'hA000_0001);

        // Test 5: capture and pop together while full.
        proc_clk_in = 1'b1; wb_en = 1'b1; wb_reg = 5'd19; wb_data = 32'hA000_0013;
        rd_ready = 1'b1;
        cyc();
        proc_clk_in = 1'b0; wb_en = 1'b0;
        chk("fullpop_count", {27'd0, c0}, 32'd16);
        chk("fullpop_drop_cnt", {16'd0, dc0}, 32'd2);
        for (int k = 0; k < 16; k++) begin
            int e;
            e = (k < 15) ? k + 2 : 19;
            chk($sformatf("drain%0d_valid", k), {31'd0, v0}, 32'd1);
            chk($sformatf("drain%0d_reg", k), {27'd0, r0}, 32'(e));
            chk($sformatf("drain%0d_data", k), d0, 32'hA000_0000 + 32'(e));
            cyc();
        end
        chk("drained_count", {27'd0, c0}, 32'd0);
        chk("drained_valid", {31'd0, v0}, 32'd0);
        chk("overflow_sticky", {31'd0, of0}, 32'd1);

        // Test 6: reset with 7 entries queued and a capture in the reset cycle.
        rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) write_pulse(5'd10 + 5'(i), 32'hB000_0000 + 32'(i));
        chk("pre_rst_count", {27'd0, c0}, 32'd7);
        reset = 1'b1; proc_clk_in = 1'b1; wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'h9999_9999;
        cyc();
        reset = 1'b0;
        chk("mid_rst_count", {27'd0, c0}, 32'd0);
        chk("mid_rst_valid", {31'd0, v0}, 32'd0);
        chk("mid_rst_overflow", {31'd0, of0}, 32'd0);
        chk("mid_rst_drop_cnt", {16'd0, dc0}, 32'd0);
        cyc();
        chk("no_false_edge", {27'd0, c0}, 32'd0);
        proc_clk_in = 1'b0; wb_en = 1'b0;
        cyc();
        write_pulse(5'd7, 32'h7777_7777);
        write_pulse(5'd0, 32'h0000_0BAD);
        write_pulse(5'd8, 32'h8888_8888);
        chk("post_rst_count", {27'd0, c0}, 32'd2);
        chk("post_rst_reg_a", {27'd0, r0}, 32'd7);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("stamp_a", s0, 32'd0);
`endif
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("post_rst_reg_b", {27'd0, r0}, 32'd8);
        chk("post_rst_data_b", d0, 32'h8888_8888);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("stamp_b", s0, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream observer of the processor top level. Consumes the exported writeback signals (o_ctrl_writeEnable, o_ctrl_writeReg, o_data_writeReg) and the divided processor_clock.
- Captures one entry per committed register write into a FIFO, for readout by a bench or debug port.
- Runs entirely on the undivided master clock.
- Samples processor_clock as a plain data input; it is never used as a clock.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2, minimum 2.
- LOG_R0, 0, when 1, writes to register 0 are also logged.
- DROP_W, 16, width of the saturating dropped-entry counter.

Ports:
- clock  in  1  master clock; the same net that drives imem/dmem.
- reset  in  1  synchronous, active-high.
- proc_clk_in  in  1  processor_clock, sampled as data.
- wb_en  in  1  regfile write enable from the processor.
- wb_reg  in  5  destination register.
- wb_data  in  32  write data.
- rd_valid  out  1  head entry is available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_reg  out  5  head entry register.
- rd_data  out  32  head entry data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when any entry is dropped.
- drop_cnt  out  DROP_W  saturating count of dropped entries.

Behaviour:
- Clock and reset:
  - Single clock domain: clock.
  - reset is synchronous, active-high, and takes priority over every other event.
- Reset values:
  - rd_valid=0, count=0, overflow=0, drop_cnt=0.
  - rd_reg=0, rd_data=0.
  - Read and write pointers = 0.
  - pclk_q = 1, so that a proc_clk_in already high on release does not produce a false edge.
- Event detect:
  - pclk_q registers proc_clk_in every cycle.
  - cap = proc_clk_in & ~pclk_q & wb_en & (LOG_R0 | (wb_reg != 0)).
  - At most one capture per processor_clock period.
  - wb_en held high across several master cycles gives exactly one entry.
- Push: when cap=1 and the FIFO is not full (or a pop happens in the same cycle), store {wb_reg, wb_data} at wptr and increment wptr (mod DEPTH).
- Pop:
  - Occurs when rd_valid & rd_ready; increments rptr.
  - rd_reg/rd_data show the entry at rptr; they are driven from registers or from the array read at rptr.
  - Their value is undefined when rd_valid=0.
- Latency: an entry captured in cycle N appears with rd_valid=1 in cycle N+1. There is no fall-through.
- Full (count==DEPTH):
  - With cap and no pop: the entry is dropped, overflow is set, drop_cnt increments (saturating at all-ones), and FIFO contents are unchanged.
  - With cap and pop in the same cycle: both occur, count stays DEPTH, and nothing is dropped.
- Empty (count==0): rd_valid=0 and a pop request is ignored. With cap, count becomes 1 next cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointer wrap: pointers carry one extra bit, so full and empty are distinguished by the MSB. Wrap-around is exercised by continuous traffic.
- Reset mid-operation: all entries are discarded, overflow and drop_cnt clear, and captures in the reset cycle are ignored.
- Ordering: entries are read out in strict capture order.

Optional Feature:
- Macro: WB_TRACE_TIMESTAMP_EN.
- When defined:
  - Adds a 32-bit free-running stamp counter that increments on every proc_clk_in rising edge, whether or not the edge is captured. It resets to 0 and wraps modulo 2^32.
  - Each entry also stores the counter value taken before the increment for that edge.
  - Adds output port rd_stamp (out, 32), aligned with rd_reg/rd_data.
- When undefined: no counter and no rd_stamp port; the array is 37 bits wide.

Decomposition:
- Package wb_trace_pkg holds:
  - REG_W=5, DATA_W=32, STAMP_W=32.
  - A packed struct wb_entry_t {reg, data[, stamp]}.
- One sub-module: wb_trace_fifo, a generic synchronous FIFO parameterised by width and DEPTH with push, pop, full, empty and count.
- The top level holds edge detect, filter, drop accounting and the optional stamp.

Test Plan:
1. Three writes: r1=0x11111111, r2=0x22222222, r3=0x33333333, one per proc_clk period, rd_ready held at 1 → three entries read out in order, each appearing one master cycle after its proc_clk edge; count returns to 0.
2. wb_en=1 held for 4 master cycles within one proc_clk period, wb_reg=5 → exactly one entry (r5) captured.
3. Write to r0 with LOG_R0=0 → no entry and count stays 0. Repeat with LOG_R0=1 → one entry with rd_reg=0.
4. rd_ready=0, DEPTH=16, 18 writes → count=16, overflow=1, drop_cnt=2. Draining returns entries 1..16 and the last two writes are absent.
5. FIFO full, then a capture and a pop in the same cycle → count stays 16, drop_cnt is unchanged, and the new entry is the last one read out.
6. Reset asserted with count=7 → next cycle count=0, rd_valid=0, overflow=0, drop_cnt=0. With WB_TRACE_TIMESTAMP_EN, stamps restart at 0 after reset.
